lcd_rgb_timing: RTL
===================

// Module: lcd_rgb_timing
// PURPOSE
//  Raster timing generator and RGB-interface driver for the ILI9341 panel, directly downstream of spi_video_memory.
//  Steps an H/V counter once per advance_pixel pulse.
//  Drives display_x/display_y/in_display_region back into the video memory.
//  Registers the returned current_pixel onto the panel's 16-bit RGB565 bus with HSYNC/VSYNC/DE, all aligned one pixel later.
// PARAMETERS
//  DISPLAY_WIDTH   240  active pixels per line
//  DISPLAY_HEIGHT  320  active lines per frame
//  H_SYNC          10   HSYNC pulse width, pixels
//  H_BACK          20   horizontal back porch, pixels
//  H_FRONT         10   horizontal front porch, pixels
//  V_SYNC          2    VSYNC pulse width, lines
//  V_BACK          2    vertical back porch, lines
//  V_FRONT         4    vertical front porch, lines
//  WIDTH_BITS      $clog2(DISPLAY_WIDTH)   display_x width
//  HEIGHT_BITS     $clog2(DISPLAY_HEIGHT)  display_y width
// PORTS
//  clk                in   1            system clock, the same clock as spi_video_memory
//  reset              in   1            synchronous, active-low reset
//  dotclk             in   1            pixel clock from spi_video_memory
//  advance_pixel      in   1            one-clk pixel-step strobe from spi_video_memory
//  current_pixel      in   16           RGB565 pixel for the previously presented coordinate
//  display_x          out  WIDTH_BITS   active-area x coordinate, to video memory
//  display_y          out  HEIGHT_BITS  active-area y coordinate, to video memory
//  in_display_region  out  1            current coordinate lies in the active area
//  frame_start        out  1            one-clk pulse at each frame wrap
//  lcd_dotclk         out  1            dotclk passthrough, combinational
//  lcd_hsync          out  1            HSYNC, active low
//  lcd_vsync          out  1            VSYNC, active low
//  lcd_de             out  1            data enable, active high
//  lcd_data           out  16           RGB565 panel bus
// BEHAVIOUR
//  - Derived totals:
//    - H_TOTAL = H_SYNC+H_BACK+DISPLAY_WIDTH+H_FRONT (280).
//    - V_TOTAL = V_SYNC+V_BACK+DISPLAY_HEIGHT+V_FRONT (328).
//    - h_cnt width = $clog2(H_TOTAL); v_cnt width = $clog2(V_TOTAL).
//  - Reset (reset==0 at a clk edge), taking effect on that edge, including mid-frame:
//    - h_cnt=0, v_cnt=0.
//    - display_x=0, display_y=0, in_display_region=0, frame_start=0.
//    - lcd_hsync=1, lcd_vsync=1, lcd_de=0, lcd_data=0.
//    - advance_pixel is ignored while reset==0.
//  - Every output except lcd_dotclk is registered. Nothing changes on a clk edge where advance_pixel==0, except frame_start, which drops to 0.
//  - Horizontal FSM, indexed by h_cnt: SYNC [0,H_SYNC) -> BACK -> ACTIVE [H_SYNC+H_BACK, +DISPLAY_WIDTH) -> FRONT -> wraps to SYNC.
//  - Vertical FSM, same phase order over v_cnt; it advances only on the tick where h_cnt wraps H_TOTAL-1 -> 0.
//  - On each tick (advance_pixel==1):
//    - Stage 2 captures the pre-tick stage-1 state:
//      - lcd_hsync <= ~(old h in SYNC).
//      - lcd_vsync <= ~(old v in SYNC).
//      - lcd_de <= old in_display_region.
//      - lcd_data <= old in_display_region ? current_pixel : 16'h0000.
//    - Counters step. Stage 1 is updated from the new counters:
//      - in_display_region = (h in ACTIVE) && (v in ACTIVE).
//      - display_x = h_cnt-(H_SYNC+H_BACK) when in_display_region, else 0.
//      - display_y = v_cnt-(V_SYNC+V_BACK) when v in ACTIVE, else 0.
//    - frame_start = 1 for exactly one clk when the counters wrap (H_TOTAL-1, V_TOTAL-1) -> (0,0). It does not pulse on reset release.
//  - Latency: coordinate presented at tick N; current_pixel sampled at tick N+1. The video memory guarantees the pixel is valid within one pixel slot.
//  - lcd_hsync/lcd_vsync/lcd_de/lcd_data are always mutually aligned, all one pixel behind stage 1.
//  - Arithmetic: subtraction only inside the ACTIVE phase, so no underflow. Coordinates never exceed DISPLAY_WIDTH-1 / DISPLAY_HEIGHT-1.
//  - advance_pixel held high continuously: the block steps every clk, with no other behavioural change.
// TESTING
//  1. reset=0 for 8 clks with advance_pixel pulsing -> all outputs at reset values, counters frozen, no frame_start.
//  2. Release reset, count ticks:
//     - lcd_hsync low on ticks 1..10 of each line.
//     - lcd_vsync low during lines 0-1 (ticks 1..560).
//     - in_display_region stays 0 for lines 0-3.
//  3. Line 4:
//     - h=30 -> display_x=0, display_y=0, in_display_region=1.
//     - h=269 -> display_x=239.
//     - h=270 -> in_display_region=0, display_x=0.
//  4. Model current_pixel = {display_y[7:0], display_x[7:0]} of the previous tick.
//     - lcd_data matches it on every DE cycle.
//     - lcd_de is high exactly 240 ticks per active line, 320 lines per frame.
//     - lcd_data=0 whenever lcd_de=0.
//  5. After 91840 ticks -> frame_start pulses once for 1 clk, counters back to (0,0), second frame repeats test 3 exactly.
//  6. Assert reset at line 100, h=150 -> next clk all outputs at reset values; after release, timing restarts from (0,0).

Source files
------------

// File: rtl/lcd_rgb_timing_if.sv
// Bus between the video memory and the LCD raster timing block.
// The video memory side feeds dotclk, the pixel strobe and the pixel data.
// It reads back the active-area coordinate.
// The panel-facing RGB565/sync outputs are grouped here as well.
interface lcd_rgb_timing_if #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 9
);
    // Video memory -> timing block
    logic                   dotclk;
    logic                   advance_pixel;
    logic [15:0]            current_pixel;

    // Timing block -> video memory
    logic [WIDTH_BITS-1:0]  display_x;
    logic [HEIGHT_BITS-1:0] display_y;
    logic                   in_display_region;
    logic                   frame_start;

    // Timing block -> panel
    logic                   lcd_dotclk;
    logic                   lcd_hsync;
    logic                   lcd_vsync;
    logic                   lcd_de;
    logic [15:0]            lcd_data;

    // Video memory / panel side
    modport master (
        output dotclk, advance_pixel, current_pixel,
        input  display_x, display_y, in_display_region, frame_start,
        input  lcd_dotclk, lcd_hsync, lcd_vsync, lcd_de, lcd_data
    );

    // Raster timing block side
    modport slave (
        input  dotclk, advance_pixel, current_pixel,
        output display_x, display_y, in_display_region, frame_start,
        output lcd_dotclk, lcd_hsync, lcd_vsync, lcd_de, lcd_data
    );
endinterface

// File: rtl/lcd_rgb_timing.sv
// Raster timing generator and RGB565 driver for the ILI9341 RGB interface.
// Stage 1 (h/v counters, coordinate outputs) steps once per advance_pixel.
// Stage 2 (sync/DE/data) registers the pre-tick stage-1 state together with
// the pixel the video memory returns.
// Stage 2 therefore trails stage 1 by exactly one pixel slot.
module lcd_rgb_timing #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int H_SYNC         = 10,
    parameter int H_BACK         = 20,
    parameter int H_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 2,
    parameter int V_FRONT        = 4,
    parameter int WIDTH_BITS     = $clog2(DISPLAY_WIDTH),
    parameter int HEIGHT_BITS    = $clog2(DISPLAY_HEIGHT)
) (
    input  logic            clk,
    input  logic            reset,
    lcd_rgb_timing_if.slave bus
);

    localparam int H_TOTAL = H_SYNC + H_BACK + DISPLAY_WIDTH + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + DISPLAY_HEIGHT + V_FRONT;
    localparam int H_BITS  = $clog2(H_TOTAL);
    localparam int V_BITS  = $clog2(V_TOTAL);

    // Last count of each phase; the FSMs leave a phase on these values.
    localparam logic [H_BITS-1:0] H_SYNC_LAST  = H_BITS'(H_SYNC - 1);
    localparam logic [H_BITS-1:0] H_BACK_LAST  = H_BITS'(H_SYNC + H_BACK - 1);
    localparam logic [H_BITS-1:0] H_ACT_LAST   = H_BITS'(H_SYNC + H_BACK + DISPLAY_WIDTH - 1);
    localparam logic [H_BITS-1:0] H_LAST       = H_BITS'(H_TOTAL - 1);
    localparam logic [H_BITS-1:0] H_ACT_START  = H_BITS'(H_SYNC + H_BACK);

    localparam logic [V_BITS-1:0] V_SYNC_LAST  = V_BITS'(V_SYNC - 1);
    localparam logic [V_BITS-1:0] V_BACK_LAST  = V_BITS'(V_SYNC + V_BACK - 1);
    localparam logic [V_BITS-1:0] V_ACT_LAST   = V_BITS'(V_SYNC + V_BACK + DISPLAY_HEIGHT - 1);
    localparam logic [V_BITS-1:0] V_LAST       = V_BITS'(V_TOTAL - 1);
    localparam logic [V_BITS-1:0] V_ACT_START  = V_BITS'(V_SYNC + V_BACK);

    // Both FSMs walk the same phase order; count 0 always lies in SYNC.
    typedef enum logic [1:0] {
        PH_SYNC,
        PH_BACK,
        PH_ACTIVE,
        PH_FRONT
    } phase_t;

    // Stage-1 state
    logic [H_BITS-1:0] h_cnt;
    logic [V_BITS-1:0] v_cnt;
    phase_t            h_phase;
    phase_t            v_phase;

    // Values stage 1 takes on the next tick
    logic [H_BITS-1:0]      h_cnt_next;
    logic [V_BITS-1:0]      v_cnt_next;
    phase_t                 h_phase_next;
    phase_t                 v_phase_next;
    logic                   h_wrap;
    logic                   v_wrap;
    logic                   frame_wrap;
    logic                   region_next;
    logic [WIDTH_BITS-1:0]  x_next;
    logic [HEIGHT_BITS-1:0] y_next;

    // The panel dot clock is the video memory's pixel clock, passed straight through.
    assign bus.lcd_dotclk = bus.dotclk;

    // Next counter, phase and coordinate values for the coming tick.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
        h_wrap       = (h_cnt == H_LAST);
        v_wrap       = (v_cnt == V_LAST);
        frame_wrap   = h_wrap && v_wrap;
        h_cnt_next   = h_wrap ? '0 : h_cnt + 1'b1;
        v_cnt_next   = v_cnt;
        h_phase_next = h_phase;
        v_phase_next = v_phase;

        case (h_phase)
            PH_SYNC:   if (h_cnt == H_SYNC_LAST) h_phase_next = PH_BACK;
            PH_BACK:   if (h_cnt == H_BACK_LAST) h_phase_next = PH_ACTIVE;
            PH_ACTIVE: if (h_cnt == H_ACT_LAST)  h_phase_next = PH_FRONT;
            PH_FRONT:  if (h_wrap)               h_phase_next = PH_SYNC;
            default:                             h_phase_next = PH_SYNC;
        endcase

        // The vertical side moves only when a line completes.
        if (h_wrap) begin
            v_cnt_next = v_wrap ? '0 : v_cnt + 1'b1;
            case (v_phase)
                PH_SYNC:   if (v_cnt == V_SYNC_LAST) v_phase_next = PH_BACK;
                PH_BACK:   if (v_cnt == V_BACK_LAST) v_phase_next = PH_ACTIVE;
                PH_ACTIVE: if (v_cnt == V_ACT_LAST)  v_phase_next = PH_FRONT;
                PH_FRONT:  if (v_wrap)               v_phase_next = PH_SYNC;
                default:                             v_phase_next = PH_SYNC;
            endcase
        end

        // Offsets are subtracted only inside ACTIVE, so they cannot underflow.
        region_next = (h_phase_next == PH_ACTIVE) && (v_phase_next == PH_ACTIVE);
        x_next      = region_next ? WIDTH_BITS'(h_cnt_next - H_ACT_START) : '0;
        y_next      = (v_phase_next == PH_ACTIVE) ? HEIGHT_BITS'(v_cnt_next - V_ACT_START) : '0;
    end

    // Stage-1 FSM state, stage-2 panel outputs and frame pulse, all stepped by advance_pixel.
    always_ff @(posedge clk) begin
        // NOTE: the reset branch clears only control state and output registers; there is no storage array to clear.
        if (!reset) begin
            h_cnt                 <= '0;
            v_cnt                 <= '0;
            h_phase               <= PH_SYNC;
            v_phase               <= PH_SYNC;
            bus.display_x         <= '0;
            bus.display_y         <= '0;
            bus.in_display_region <= 1'b0;
            bus.frame_start       <= 1'b0;
            bus.lcd_hsync         <= 1'b1;
            bus.lcd_vsync         <= 1'b1;
            bus.lcd_de            <= 1'b0;
            bus.lcd_data          <= '0;
        end else begin
            bus.frame_start <= 1'b0;
            if (bus.advance_pixel) begin
                // NOTE: non-blocking assignments let stage 2 read the pre-tick stage-1 values below.
                bus.lcd_hsync <= (h_phase != PH_SYNC);
                bus.lcd_vsync <= (v_phase != PH_SYNC);
                bus.lcd_de    <= bus.in_display_region;
                bus.lcd_data  <= bus.in_display_region ? bus.current_pixel : 16'h0000;

                h_cnt                 <= h_cnt_next;
                v_cnt                 <= v_cnt_next;
                h_phase               <= h_phase_next;
                v_phase               <= v_phase_next;
                bus.display_x         <= x_next;
                bus.display_y         <= y_next;
                bus.in_display_region <= region_next;
                bus.frame_start       <= frame_wrap;
            end
        end
    end

endmodule
